// File: rtl/puf_frame_rx.sv
// Receiver for the 64-bit arbiter-PUF result frame: 8N1 UART deserialiser, frame assembly,
// marker check, majority vote over the 8 repeated responses and challenge-sequence tracking.
module puf_frame_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int GAP_BITS     = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rxd,
  output logic        frame_valid,
  output logic [15:0] chal,
  output logic [7:0]  resp,
  output logic        maj,
  output logic        tie,
  output logic        stable,
  output logic        frame_err,
  output logic        seq_err,
  output logic        sweep_done
);

  localparam int CW       = $clog2(CLKS_PER_BIT);
  localparam int GAP_CLKS = GAP_BITS * CLKS_PER_BIT;
  localparam int GW       = $clog2(GAP_CLKS);

  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BRK
  } state_t;

  state_t          r_state;
  logic            r_rxd_s1;
  logic            r_rxd_s2;
  logic [CW-1:0]   r_clk_cnt;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_byte;
  logic [2:0]      r_byte_idx;
  logic [55:0]     r_shift;
  logic [GW-1:0]   r_gap_cnt;
  logic            r_first;

  logic [63:0]     w_frame;
  logic [3:0]      w_pop;
  logic            w_good;
  logic [15:0]     w_next_chal;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  // Only the previous seven bytes are kept; the byte in flight completes the frame.
  assign w_frame     = {r_shift, r_byte};
  assign w_pop       = popcount8(w_frame[11:4]);
  assign w_good      = (w_frame[47:28] == 20'hC0A0A) &&
                       (w_frame[27:12] == 16'hFFFF) &&
                       (w_frame[3:0]   == 4'hC);
  assign w_next_chal = chal + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rxd_s1    <= 1'b1;
      r_rxd_s2    <= 1'b1;
      r_clk_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_byte      <= '0;
      r_byte_idx  <= '0;
      r_shift     <= '0;
      r_gap_cnt   <= '0;
      r_first     <= 1'b1;
      frame_valid <= 1'b0;
      chal        <= '0;
      resp        <= '0;
      maj         <= 1'b0;
      tie         <= 1'b0;
      stable      <= 1'b0;
      frame_err   <= 1'b0;
      seq_err     <= 1'b0;
      sweep_done  <= 1'b0;
    end else begin
      r_rxd_s1    <= rxd;
      r_rxd_s2    <= r_rxd_s1;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      seq_err     <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_clk_cnt <= '0;
          r_bit_cnt <= '0;
          if (!r_rxd_s2) begin
            r_state   <= S_START;
            r_gap_cnt <= '0;
          end else if (r_byte_idx != 3'd0) begin
            // A stalled partial frame is dropped after a long idle gap.
            if (r_gap_cnt == GAP_LAST) begin
              frame_err  <= 1'b1;
              r_byte_idx <= '0;
              r_gap_cnt  <= '0;
            end else begin
              r_gap_cnt <= r_gap_cnt + 1'b1;
            end
          end else begin
            r_gap_cnt <= '0;
          end
        end

        S_START: begin
          if (r_clk_cnt == HALF_LAST) begin
            r_clk_cnt <= '0;
            r_state   <= r_rxd_s2 ? S_IDLE : S_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (r_clk_cnt == FULL_LAST) begin
            r_clk_cnt <= '0;
            r_byte    <= {r_rxd_s2, r_byte[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= S_STOP;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (r_clk_cnt == FULL_LAST) begin
            r_clk_cnt <= '0;
            if (r_rxd_s2) begin
              r_state    <= S_IDLE;
              r_shift    <= w_frame[55:0];
              r_byte_idx <= r_byte_idx + 1'b1;
              if (r_byte_idx == 3'd7) begin
                if (w_good) begin
                  frame_valid <= 1'b1;
                  chal        <= w_frame[63:48];
                  resp        <= w_frame[11:4];
                  maj         <= (w_pop >= 4'd5);
                  tie         <= (w_pop == 4'd4);
                  stable      <= (w_frame[11:4] == 8'h00) || (w_frame[11:4] == 8'hFF);
                  seq_err     <= !r_first && (w_frame[63:48] != w_next_chal);
                  r_first     <= 1'b0;
                  if (w_frame[63:48] == 16'hFFFF) begin
                    sweep_done <= 1'b1;
                  end
                end else begin
                  frame_err <= 1'b1;
                end
              end
            end else begin
              frame_err  <= 1'b1;
              r_byte_idx <= '0;
              r_state    <= S_BRK;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        S_BRK: begin
          r_clk_cnt <= '0;
          if (r_rxd_s2) begin
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_frame_rx.sv
// Directed bench for puf_frame_rx: serial byte driver, expected-event queue, decoupled monitor.
module tb_puf_frame_rx;

  localparam int CPB = 16;
  localparam int GAP = 20;

  logic        clk;
  logic        rst_n;
  logic        rxd;
  logic        frame_valid;
  logic [15:0] chal;
  logic [7:0]  resp;
  logic        maj;
  logic        tie;
  logic        stable;
  logic        frame_err;
  logic        seq_err;
  logic        sweep_done;

  puf_frame_rx #(.CLKS_PER_BIT(CPB), .GAP_BITS(GAP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rxd         (rxd),
    .frame_valid (frame_valid),
    .chal        (chal),
    .resp        (resp),
    .maj         (maj),
    .tie         (tie),
    .stable      (stable),
    .frame_err   (frame_err),
    .seq_err     (seq_err),
    .sweep_done  (sweep_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_err;
    logic [15:0] chal;
    logic [7:0]  resp;
    logic        maj;
    logic        tie;
    logic        stable;
    logic        seq;
    logic        sweep;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    n_cmp++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic exp_good(input logic [15:0] c, input logic [7:0] r, input logic m,
                          input logic t, input logic s, input logic sq, input logic sw);
    exp_t e;
    e.is_err = 1'b0; e.chal = c; e.resp = r; e.maj = m; e.tie = t;
    e.stable = s; e.seq = sq; e.sweep = sw;
    q.push_back(e);
  endtask

  task automatic exp_err();
    exp_t e;
    e = '0;
    e.is_err = 1'b1;
    q.push_back(e);
  endtask

  task automatic bit_t(input logic v);
    rxd = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bit_t(1'b0);
    for (int i = 0; i < 8; i++) bit_t(b[i]);
    bit_t(stop);
  endtask

  task automatic send_bytes(input logic [63:0] w, input int first, input int last);
    for (int i = first; i <= last; i++) send_byte(w[63 - 8*i -: 8], 1'b1);
  endtask

  function automatic logic [63:0] mk(input logic [15:0] c, input logic [7:0] r);
    return {c, 20'hC0A0A, 16'hFFFF, r, 4'hC};
  endfunction

  // Monitor: every output event consumes one expected entry.
  always @(negedge clk) begin
    if (rst_n && (frame_valid || frame_err)) begin
      exp_t e;
      n_cmp++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got valid=%b err=%b chal=%h, required no event",
                 frame_valid, frame_err, chal);
      end else begin
        e = q.pop_front();
        if (e.is_err) begin
          if (!(frame_err && !frame_valid)) begin
            n_fail++;
            $display("FAIL err_event: got valid=%b err=%b, required valid=0 err=1",
                     frame_valid, frame_err);
          end
        end else if ({frame_valid, frame_err, chal, resp, maj, tie, stable, seq_err, sweep_done} !==
                     {1'b1, 1'b0, e.chal, e.resp, e.maj, e.tie, e.stable, e.seq, e.sweep}) begin
          n_fail++;
          $display("FAIL good_frame: got v=%b e=%b chal=%h resp=%h maj=%b tie=%b st=%b seq=%b sw=%b, required v=1 e=0 chal=%h resp=%h maj=%b tie=%b st=%b seq=%b sw=%b",
                   frame_valid, frame_err, chal, resp, maj, tie, stable, seq_err, sweep_done,
                   e.chal, e.resp, e.maj, e.tie, e.stable, e.seq, e.sweep);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1);
  end

  initial begin
    logic [63:0] w;
    rxd   = 1'b1;
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("reset_outputs", {frame_valid, frame_err, seq_err, sweep_done, maj, tie, stable, chal, resp},
          64'h0);
    rst_n = 1'b1;
    idle(20);

    exp_good(16'h0001, 8'hFF, 1, 0, 1, 0, 0);
    send_bytes(mk(16'h0001, 8'hFF), 0, 7);
    exp_good(16'h0002, 8'h0F, 0, 1, 0, 0, 0);
    send_bytes(mk(16'h0002, 8'h0F), 0, 7);
    exp_good(16'h0005, 8'h1F, 1, 0, 0, 1, 0);
    send_bytes(mk(16'h0005, 8'h1F), 0, 7);
    exp_good(16'hFFFF, 8'h00, 0, 0, 1, 1, 1);
    send_bytes(mk(16'hFFFF, 8'h00), 0, 7);
    exp_good(16'h0000, 8'h07, 0, 0, 0, 0, 1);
    send_bytes(mk(16'h0000, 8'h07), 0, 7);
    check("sweep_sticky", {63'h0, sweep_done}, 64'h1);

    // Corrupted marker byte 2 (C0 -> C1).
    exp_err();
    w = mk(16'h0001, 8'hAA) ^ 64'h0000_0100_0000_0000;
    send_bytes(w, 0, 7);
    check("chal_hold_bad", {48'h0, chal}, 64'h0);

    // Stop bit low on byte 3, then idle, then a good frame.
    w = mk(16'h0001, 8'h55);
    send_bytes(w, 0, 2);
    exp_err();
    send_byte(w[39:32], 1'b0);
    idle(40);
    exp_good(16'h0001, 8'h55, 0, 1, 0, 0, 1);
    send_bytes(w, 0, 7);

    // Partial frame followed by a long gap.
    exp_err();
    send_bytes(mk(16'h0002, 8'h3C), 0, 3);
    idle(400);

    // Single-cycle glitch on idle line: no event expected.
    rxd = 1'b0;
    @(posedge clk);
    #1;
    idle(100);

    exp_good(16'h0002, 8'h3C, 0, 1, 0, 0, 1);
    send_bytes(mk(16'h0002, 8'h3C), 0, 7);

    // Reset in the middle of byte 5.
    w = mk(16'h0003, 8'h81);
    send_bytes(w, 0, 4);
    bit_t(1'b0);
    bit_t(w[16]);
    bit_t(w[17]);
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midreset_outputs", {frame_valid, frame_err, seq_err, sweep_done, maj, tie, stable, chal, resp},
          64'h0);
    rst_n = 1'b1;
    idle(40);
    exp_good(16'h1234, 8'hE7, 1, 0, 0, 0, 0);
    send_bytes(mk(16'h1234, 8'hE7), 0, 7);

    idle(60);
    check("queue_drained", 64'(q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
